// File: rtl/ram_port_master.sv
// CPU-side initiator for one RAM read channel and one RAM write channel.
// Turns a single valid/ready load/store into a one-cycle size pulse, waits for is_ready, and returns extended data.
module ram_port_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] rd_address,
    output logic [1:0]  rd_sig_read,
    input  logic [31:0] rd_data,
    input  logic        rd_is_ready,
    output logic [31:0] wr_address,
    output logic [1:0]  wr_sig_write,
    output logic [31:0] wr_data,
    input  logic        wr_is_ready
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_DRAIN, S_RESP
    } state_t;

    state_t state, state_n;

    logic          write_q, write_n;
    logic [1:0]    size_q, size_n;
    logic          signed_q, signed_n;
    logic          err_q, err_n;
    logic [31:0]   rdata_q, rdata_n;
    logic [CW-1:0] cnt, cnt_n;

    logic          req_ready_n, resp_valid_n, resp_error_n;
    logic [31:0]   resp_rdata_n;
    logic [31:0]   rd_address_n, wr_address_n, wr_data_n;
    logic [1:0]    rd_sig_read_n, wr_sig_write_n;

    logic accept, sel_ready, timeout;

    assign accept    = req_valid && req_ready;
    // Only the channel the request was issued on is ever consulted.
    assign sel_ready = write_q ? wr_is_ready : rd_is_ready;
    assign timeout   = (cnt == CNT_LAST);

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz, input logic sg);
        case (sz)
            2'd1:    extend = {{24{sg & d[7]}}, d[7:0]};
            2'd2:    extend = {{16{sg & d[15]}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    // NOTE: async reset covers every flop, including the captured read data, so no X can reach resp_rdata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'd0;
            signed_q     <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            cnt          <= '0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_error   <= 1'b0;
            resp_rdata   <= '0;
            rd_address   <= '0;
            rd_sig_read  <= 2'd0;
            wr_address   <= '0;
            wr_sig_write <= 2'd0;
            wr_data      <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state        <= state_n;
            write_q      <= write_n;
            size_q       <= size_n;
            signed_q     <= signed_n;
            err_q        <= err_n;
            rdata_q      <= rdata_n;
            cnt          <= cnt_n;
            req_ready    <= req_ready_n;
            resp_valid   <= resp_valid_n;
            resp_error   <= resp_error_n;
            resp_rdata   <= resp_rdata_n;
            rd_address   <= rd_address_n;
            rd_sig_read  <= rd_sig_read_n;
            wr_address   <= wr_address_n;
            wr_sig_write <= wr_sig_write_n;
            wr_data      <= wr_data_n;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_n unassigned (no latch).
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = (req_size == 2'd0) ? S_RESP : S_ISSUE;
            S_ISSUE: state_n = S_GUARD;
            S_GUARD: state_n = S_WAIT;
            S_WAIT: begin
                if (sel_ready)    state_n = S_RESP;
                else if (timeout) state_n = S_DRAIN;
            end
            S_DRAIN: if (sel_ready) state_n = S_IDLE;
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        write_n        = write_q;
        size_n         = size_q;
        signed_n       = signed_q;
        err_n          = err_q;
        rdata_n        = rdata_q;
        cnt_n          = cnt;
        req_ready_n    = (state_n == S_IDLE);
        resp_valid_n   = 1'b0;
        resp_error_n   = 1'b0;
        resp_rdata_n   = resp_rdata;
        rd_address_n   = rd_address;
        rd_sig_read_n  = rd_sig_read;
        wr_address_n   = wr_address;
        wr_sig_write_n = wr_sig_write;
        wr_data_n      = wr_data;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    write_n  = req_write;
                    size_n   = req_size;
                    signed_n = req_signed;
                    err_n    = (req_size == 2'd0);
                    if (req_size != 2'd0) begin
                        if (req_write) begin
                            wr_sig_write_n = req_size;
                            wr_address_n   = req_addr;
                            wr_data_n      = req_wdata;
                        end else begin
                            rd_sig_read_n = req_size;
                            rd_address_n  = req_addr;
                        end
                    end
                end
            end
            S_ISSUE: begin
                // The responder latches on the 0 -> nonzero edge, so the size code lives for one cycle.
                if (write_q) wr_sig_write_n = 2'd0;
                else         rd_sig_read_n  = 2'd0;
            end
            S_GUARD: cnt_n = '0;
            S_WAIT: begin
                if (sel_ready) begin
                    if (!write_q) rdata_n = rd_data;
                end else if (timeout) begin
                    err_n        = 1'b1;
                    resp_valid_n = 1'b1;
                    resp_error_n = 1'b1;
                    resp_rdata_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_RESP: begin
                resp_valid_n = 1'b1;
                resp_error_n = err_q;
                resp_rdata_n = (err_q || write_q) ? 32'd0 : extend(rdata_q, size_q, signed_q);
            end
            default: ;
        endcase
    end

endmodule
